abc_seq_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one a/b/c handshake resource between NREQ requesters.
- On granting a requester it emits the protocol "a rises, then b for B_LEN consecutive cycles, then c for one cycle".
- With the default B_LEN=2 this is exactly $rose(a) |=> b[*2] ##1 c.
- Sits in front of the a/b/c datapath in place of free-running stimulus; drives a, b and c itself.

---
 rtl/abc_seq_arbiter.sv | 175 +++++++++++++++++
 tb/tb_abc_seq_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/abc_seq_arbiter.sv
// Round-robin arbiter that shares one a/b/c handshake resource between NREQ requesters.
// Define ABC_SEQ_ASSERT_EN to compile the embedded protocol assertions.
module abc_seq_arbiter #(
  parameter int NREQ  = 4,
  parameter int B_LEN = 2,
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int CW   = (B_LEN > 0) ? $clog2(B_LEN + 1) : 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant,
  output logic            a,
  output logic            b,
  output logic            c,
  output logic            busy,
  output logic            done,
  output logic [IW-1:0]   done_id
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    START    = 2'd1,
    BURST    = 2'd2,
    COMPLETE = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   gidx_q, gidx_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic            a_q, a_d;
  logic            b_q, b_d;
  logic            c_q, c_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [IW-1:0]   done_id_q, done_id_d;

  // In COMPLETE the pointer is already moving to the granted index, so arbitrate from there.
  logic [IW-1:0]     arb_ptr;
  logic [2*NREQ-1:0] req_dbl;
  logic [NREQ-1:0]   req_rot;
  logic              arb_found;
  logic [IW-1:0]     arb_idx;

  assign arb_ptr = (state_q == COMPLETE) ? gidx_q : ptr_q;
  assign req_dbl = {req, req};

  always_comb begin
    req_rot = req_dbl[NREQ-1:0];
    if (int'(arb_ptr) + 1 < NREQ) begin
      req_rot = req_dbl[NREQ-1:0];
      for (int i = 0; i < NREQ; i++) begin
        req_rot[i] = req_dbl[i + int'(arb_ptr) + 1];
      end
    end
  end

  // Lowest set bit of the rotated vector is the closest requester after the pointer.
  always_comb begin
    int unsigned sum;
    arb_found = 1'b0;
    arb_idx   = '0;
    sum       = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        arb_found = 1'b1;
        sum       = int'(arb_ptr) + 1 + i;
        if (sum >= NREQ) begin
          sum = sum - NREQ;
        end
        arb_idx   = IW'(sum);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    case (state_q)
      IDLE: begin
        if (arb_found) begin
          state_d = START;
          gidx_d  = arb_idx;
        end
      end
      START: begin
        cnt_d   = CW'(B_LEN - 1);
        state_d = BURST;
      end
      BURST: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = COMPLETE;
        end
      end
      COMPLETE: begin
        ptr_d = gidx_q;
        if (arb_found) begin
          state_d = START;
          gidx_d  = arb_idx;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every port comes straight from a flop.
  always_comb begin
    a_d       = (state_d == START);
    b_d       = (state_d == BURST);
    c_d       = (state_d == COMPLETE);
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == COMPLETE);
    done_id_d = (state_d == COMPLETE) ? gidx_d : '0;
    grant_d   = '0;
    if (state_d != IDLE) begin
      grant_d = NREQ'(1) << gidx_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ptr_q     <= IW'(NREQ - 1);
      gidx_q    <= '0;
      grant_q   <= '0;
      a_q       <= 1'b0;
      b_q       <= 1'b0;
      c_q       <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      gidx_q    <= gidx_d;
      grant_q   <= grant_d;
      a_q       <= a_d;
      b_q       <= b_d;
      c_q       <= c_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
    end
  end

  assign grant   = grant_q;
  assign a       = a_q;
  assign b       = b_q;
  assign c       = c_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign done_id = done_id_q;

`ifdef ABC_SEQ_ASSERT_EN
  default clocking cb @(posedge clock); endclocking
  default disable iff (reset);

  ap_abc_seq:   assert property ($rose(a) |=> b [* B_LEN] ##1 c);
  ap_onehot:    assert property ($onehot0(grant));
  ap_c_done:    assert property (c |-> done && $stable(grant));
  ap_exclusive: assert property (!(a && b) && !(b && c) && !(a && c));
  ap_a_start:   assert property ($rose(a) |-> $past(!busy) || $past(c));
`endif

endmodule

// File: tb/tb_abc_seq_arbiter.sv
// Directed bench for abc_seq_arbiter: a per-cycle vector table on the default
// configuration plus a hand-written sequence on a B_LEN=5, NREQ=2 instance.
module tb_abc_seq_arbiter;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Default configuration instance
  logic       rst;
  logic [3:0] req;
  logic [3:0] grant;
  logic       a, b, c, busy, done;
  logic [1:0] done_id;

  abc_seq_arbiter #(.NREQ(4), .B_LEN(2)) dut (
    .clock(clk), .reset(rst), .req(req), .grant(grant),
    .a(a), .b(b), .c(c), .busy(busy), .done(done), .done_id(done_id)
  );

  // Long-burst, two-requester instance
  logic       rst2;
  logic [1:0] req2;
  logic [1:0] grant2;
  logic       a2, b2, c2, busy2, done2;
  logic [0:0] done_id2;

  abc_seq_arbiter #(.NREQ(2), .B_LEN(5)) dut2 (
    .clock(clk), .reset(rst2), .req(req2), .grant(grant2),
    .a(a2), .b(b2), .c(c2), .busy(busy2), .done(done2), .done_id(done_id2)
  );

  typedef struct packed {
    logic       rst;
    logic [3:0] req;
    logic [3:0] grant;
    logic       a, b, c, busy, done;
    logic [1:0] id;
  } vec_t;

  vec_t vecs[$];
  int   passed = 0;
  int   total  = 0;

  // ph: 0 idle, 1 a-cycle, 2 b-cycle, 3 c-cycle
  function automatic void add(logic r, logic [3:0] rq, int ph, logic [3:0] g, logic [1:0] id);
    vec_t v;
    v.rst   = r;
    v.req   = rq;
    v.grant = (ph == 0) ? 4'b0000 : g;
    v.a     = (ph == 1);
    v.b     = (ph == 2);
    v.c     = (ph == 3);
    v.busy  = (ph != 0);
    v.done  = (ph == 3);
    v.id    = (ph == 3) ? id : 2'd0;
    vecs.push_back(v);
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  initial begin
    logic [3:0] g;
    rst  = 1'b1;
    req  = 4'b0000;
    rst2 = 1'b1;
    req2 = 2'b00;

    // Reset state
    add(1, 4'b0000, 0, 4'b0000, 0);
    // Single pulsed request on requester 0
    add(0, 4'b0001, 1, 4'b0001, 0);
    add(0, 4'b0000, 2, 4'b0001, 0);
    add(0, 4'b0000, 2, 4'b0001, 0);
    add(0, 4'b0000, 3, 4'b0001, 0);
    add(0, 4'b0000, 0, 4'b0000, 0);
    // Fresh pointer, all requesting: 0,1,2,3,0 back-to-back
    add(1, 4'b0000, 0, 4'b0000, 0);
    for (int i = 0; i < 5; i++) begin
      g = 4'b0001 << (i % 4);
      add(0, 4'b1111, 1, g, 0);
      add(0, 4'b1111, 2, g, 0);
      add(0, 4'b1111, 2, g, 0);
      add(0, 4'b1111, 3, g, 2'(i % 4));
    end
    add(0, 4'b0000, 0, 4'b0000, 0);
    // Grant 2, then 0101 wraps to 0 before 2
    add(0, 4'b0100, 1, 4'b0100, 0);
    add(0, 4'b0000, 2, 4'b0100, 0);
    add(0, 4'b0000, 2, 4'b0100, 0);
    add(0, 4'b0000, 3, 4'b0100, 2);
    add(0, 4'b0101, 1, 4'b0001, 0);
    add(0, 4'b0101, 2, 4'b0001, 0);
    add(0, 4'b0101, 2, 4'b0001, 0);
    add(0, 4'b0101, 3, 4'b0001, 0);
    add(0, 4'b0101, 1, 4'b0100, 0);
    add(0, 4'b0000, 2, 4'b0100, 0);
    add(0, 4'b0000, 2, 4'b0100, 0);
    add(0, 4'b0000, 3, 4'b0100, 2);
    add(0, 4'b0000, 0, 4'b0000, 0);
    // Requester 1 drops req during burst: sequence still completes
    add(0, 4'b0010, 1, 4'b0010, 0);
    add(0, 4'b0010, 2, 4'b0010, 0);
    add(0, 4'b0000, 2, 4'b0010, 0);
    add(0, 4'b0000, 3, 4'b0010, 1);
    add(0, 4'b0000, 0, 4'b0000, 0);
    // Grant 3 aborted by reset in its second b cycle: no c afterwards
    add(0, 4'b1000, 1, 4'b1000, 0);
    add(0, 4'b0000, 2, 4'b1000, 0);
    add(0, 4'b0000, 2, 4'b1000, 0);
    add(1, 4'b0000, 0, 4'b0000, 0);
    add(0, 4'b0000, 0, 4'b0000, 0);
    // After reset, 1000 alone is still granted
    add(0, 4'b1000, 1, 4'b1000, 0);
    add(0, 4'b0000, 2, 4'b1000, 0);
    add(0, 4'b0000, 2, 4'b1000, 0);
    add(0, 4'b0000, 3, 4'b1000, 3);
    add(0, 4'b0000, 0, 4'b0000, 0);
    // Reset restores priority to requester 0 first
    add(1, 4'b0000, 0, 4'b0000, 0);
    add(0, 4'b1001, 1, 4'b0001, 0);
    add(0, 4'b0000, 2, 4'b0001, 0);
    add(0, 4'b0000, 2, 4'b0001, 0);
    add(0, 4'b0000, 3, 4'b0001, 0);
    add(0, 4'b0000, 0, 4'b0000, 0);

    for (int k = 0; k < vecs.size(); k++) begin
      rst = vecs[k].rst;
      req = vecs[k].req;
      @(posedge clk);
      #1;
      $display("vec %0d rst=%b req=%b -> grant=%b a=%b b=%b c=%b busy=%b done=%b id=%0d",
               k, rst, req, grant, a, b, c, busy, done, done_id);
      check($sformatf("vec%0d", k),
            {21'd0, grant, a, b, c, busy, done, done_id},
            {21'd0, vecs[k].grant, vecs[k].a, vecs[k].b, vecs[k].c,
             vecs[k].busy, vecs[k].done, vecs[k].id});
    end
    rst = 1'b0;
    req = 4'b0000;

    // B_LEN=5 instance: a, five b cycles, then c with done_id 1
    rst2 = 1'b1;
    @(posedge clk); #1;
    $display("long reset -> grant=%b a=%b b=%b c=%b busy=%b", grant2, a2, b2, c2, busy2);
    check("long_reset", {26'd0, grant2, a2, b2, c2, busy2, done2, done_id2}, 32'd0);
    rst2 = 1'b0;
    req2 = 2'b10;
    @(posedge clk); #1;
    req2 = 2'b00;
    $display("long start -> grant=%b a=%b b=%b c=%b busy=%b", grant2, a2, b2, c2, busy2);
    check("long_start", {26'd0, grant2, a2, b2, c2, busy2, done2, done_id2},
          {26'd0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      $display("long b%0d -> grant=%b a=%b b=%b c=%b busy=%b", i, grant2, a2, b2, c2, busy2);
      check($sformatf("long_b%0d", i), {26'd0, grant2, a2, b2, c2, busy2, done2, done_id2},
            {26'd0, 2'b10, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
    end
    @(posedge clk); #1;
    $display("long c -> grant=%b c=%b done=%b id=%0d", grant2, c2, done2, done_id2);
    check("long_c", {26'd0, grant2, a2, b2, c2, busy2, done2, done_id2},
          {26'd0, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1});
    @(posedge clk); #1;
    $display("long idle -> grant=%b busy=%b", grant2, busy2);
    check("long_idle", {26'd0, grant2, a2, b2, c2, busy2, done2, done_id2}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
